pe_ctx_sequencer: RTL
=====================

PE_CTX_SEQUENCER -- requirements
Module: pe_ctx_sequencer

Interface
REQ-001 Parameter CTX_DEPTH, default 16: number of context words; index width is 4 bits.
REQ-002 Parameter CTRL_W, default 11: PE control word width, fields output[10:8], op1[7:5], op2[4:2], opcode[1:0].
REQ-003 The block SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  context write strobe.
- cfg_addr  in  4  context index to write.
- cfg_wdata  in  CTRL_W  context word to write.
- start  in  1  launch a program, sampled in IDLE only.
- last_idx  in  4  index of the final context in the program, latched at start.
- iter  in  8  pass count, latched at start; 0 = run until abort.
- stall  in  1  hold issue for this cycle.
- abort  in  1  terminate the program.
- pe_ctrl  out  CTRL_W  registered control word to the PE.
- pe_ctrl_vld  out  1  pe_ctrl is a live context this cycle.
- pc  out  4  index of the next context to issue.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse with the final issued word.
- cfg_err  out  1  one-cycle pulse on a rejected config write.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-005 IDLE with start=1 and abort=0: latch last_idx and iter, set pc=0, enter RUN at the next edge.
REQ-006 In RUN with stall=0, each edge SHALL do all of the following:
- load pe_ctrl with mem[pc] and drive pe_ctrl_vld=1;
- if pc!=last_idx, increment pc;
- otherwise set pc to 0 and end the pass.
REQ-007 Latency: start sampled in cycle t gives the first pe_ctrl_vld=1, carrying context 0, in cycle t+2.
REQ-008 End of pass with remaining count=1: enter DONE. Count >1: decrement and stay in RUN. Latched iter=0: never decrement, stay in RUN.
REQ-009 DONE cycle: pe_ctrl_vld=1 with the final word and done=1; the next edge returns to IDLE.
REQ-010 In RUN with stall=1, the edge SHALL hold pc, the count and pe_ctrl, and drive pe_ctrl_vld=0.
REQ-011 Abort in RUN or DONE: enter IDLE at the next edge with pe_ctrl_vld=0 and pe_ctrl=NOP (all zero). done SHALL NOT pulse. Abort has priority over stall and end-of-pass.
REQ-012 start while busy SHALL be ignored.
REQ-013 cfg_we in IDLE SHALL write mem[cfg_addr] at that edge.
REQ-014 cfg_we while busy: the write is dropped and cfg_err=1 for the next cycle.
REQ-015 cfg_we and start in the same IDLE cycle: the write commits, and the program issues the new word.
REQ-016 last_idx=0 SHALL issue context 0 once per pass.
REQ-017 In IDLE, pe_ctrl SHALL be NOP and pe_ctrl_vld=0.

Reset
REQ-018 rst SHALL override all inputs, including mid-program, and set state=IDLE, pc=0, count=0, pe_ctrl=NOP, pe_ctrl_vld=0, done=0, cfg_err=0.
REQ-019 Context memory contents SHALL NOT be cleared by rst.

Structure
REQ-020 Shared package pea_pkg SHALL hold:
- CTRL_W and CTX_DEPTH;
- control-word field offsets and widths;
- opcode enum (ADD=00, SUB=01, MUL=11);
- port-select enum E=000, S=001, W=010, N=011;
- the NOP constant;
- the sequencer state enum.
REQ-021 Context storage SHALL be the sub-module pe_ctx_mem: CTX_DEPTH x CTRL_W, one synchronous write port, one asynchronous read port.

Verification
REQ-022 Bench SHALL cover these scenarios:
- Basic run: write ctx0=000_000_001_00, ctx1=000_001_010_00, ctx2=001_001_010_11; start with last_idx=2, iter=1 at cycle t. Required: those three words in order at cycles t+2..t+4, done=1 at t+4 only, busy low at t+5.
- Passes: last_idx=1, iter=3. Required: 6 valid words ctx0,ctx1 x3; done only with the sixth.
- Stall: stall=1 for 2 cycles mid-program. Required: vld=0 on those cycles, pe_ctrl held, no context skipped or duplicated.
- Abort: iter=0 for 20 cycles, then abort. Required: vld=0 and busy=0 the next cycle, no done pulse.
- Config rejection: cfg_we to addr 0 while busy. Required: cfg_err pulse, and a rerun shows ctx0 unchanged.
- Reset mid-run: rst mid-run. Required: all outputs at reset values the next cycle; a rerun without rewriting memory issues the original words.

Source files
------------

// File: rtl/pea_pkg.sv
// Shared definitions for the PE array: control-word layout, encodings and
// the context-sequencer state set.
package pea_pkg;

  localparam int unsigned CTRL_W    = 11;
  localparam int unsigned CTX_DEPTH = 16;

  // Control word layout: {output, op1, op2, opcode}
  localparam int unsigned OUT_OFS = 8;
  localparam int unsigned OP1_OFS = 5;
  localparam int unsigned OP2_OFS = 2;
  localparam int unsigned OPC_OFS = 0;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned OPC_W   = 2;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b11
  } opcode_e;

  typedef enum logic [SEL_W-1:0] {
    PORT_E = 3'b000,
    PORT_S = 3'b001,
    PORT_W = 3'b010,
    PORT_N = 3'b011
  } port_sel_e;

  localparam logic [CTRL_W-1:0] NOP = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pe_ctx_mem.sv
// Context word storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module pe_ctx_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 11,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pe_ctx_sequencer.sv
// Issues stored PE control words in index order, optionally for several
// passes, with stall, abort and config-write protection while running.
module pe_ctx_sequencer #(
  parameter int unsigned CTX_DEPTH = pea_pkg::CTX_DEPTH,
  parameter int unsigned CTRL_W    = pea_pkg::CTRL_W,
  localparam int unsigned IDX_W    = $clog2(CTX_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [CTRL_W-1:0] cfg_wdata,
  input  logic              start,
  input  logic [IDX_W-1:0]  last_idx,
  input  logic [7:0]        iter,
  input  logic              stall,
  input  logic              abort,
  output logic [CTRL_W-1:0] pe_ctrl,
  output logic              pe_ctrl_vld,
  output logic [IDX_W-1:0]  pc,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);
  import pea_pkg::*;

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_pc;
  logic [IDX_W-1:0]  r_last;
  logic [7:0]        r_count;
  logic [CTRL_W-1:0] r_pe_ctrl;
  logic              r_vld;
  logic              r_done;
  logic              r_cfg_err;
  logic [CTRL_W-1:0] w_rdata;
  logic              w_mem_we;

  assign w_mem_we = cfg_we && (r_state == S_IDLE);

  pe_ctx_mem #(
    .DEPTH (CTX_DEPTH),
    .WIDTH (CTRL_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_wdata),
    .i_raddr (r_pc),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_last    <= '0;
      r_count   <= '0;
      r_pe_ctrl <= CTRL_W'(NOP);
      r_vld     <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we && (r_state != S_IDLE);
      r_vld     <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pe_ctrl <= CTRL_W'(NOP);
          if (start && !abort) begin
            r_last  <= last_idx;
            r_count <= iter;
            r_pc    <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_pe_ctrl <= CTRL_W'(NOP);
          end else if (!stall) begin
            r_pe_ctrl <= w_rdata;
            r_vld     <= 1'b1;
            if (r_pc != r_last) begin
              r_pc <= r_pc + IDX_W'(1);
            end else begin
              r_pc <= '0;
              // A latched count of zero means run until aborted.
              if (r_count == 8'd1) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else if (r_count != 8'd0) begin
                r_count <= r_count - 8'd1;
              end
            end
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_pc      <= '0;
          r_pe_ctrl <= CTRL_W'(NOP);
        end
        default: begin
          r_state   <= S_IDLE;
          r_pe_ctrl <= CTRL_W'(NOP);
        end
      endcase
    end
  end

  assign pe_ctrl     = r_pe_ctrl;
  assign pe_ctrl_vld = r_vld;
  assign pc          = r_pc;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign cfg_err     = r_cfg_err;

endmodule
